z2_autoconfig_slave: RTL and testbench
======================================

// Module: z2_autoconfig_slave
// PURPOSE
//   Zorro II slave for the graphics card: Autoconfig responder at $E80000, then a 4 MB
//   memory window with a 512x16 on-chip RAM that aliases through the whole window.
//   Sits between the Zorro II buffers and the card logic. All bus inputs are asynchronous
//   and sampled on z_sample_clk (100 MHz).
// PARAMETERS
//   MANUF_ID    16'h6D6E  manufacturer ID returned at offsets $10-$16
//   PRODUCT_ID  8'h01     product ID returned at offsets $04-$06
//   ER_TYPE     8'hC7     er_Type: Zorro II, no memlist, size code 111 = 4 MB
//   RAM_AW      9         RAM word-address width; window offset bits [RAM_AW:1] select the word
// PORTS
//   z_sample_clk  in   1   sole clock, 100 MHz
//   reset         in   1   asynchronous, active-high
//   znAS          in   1   address strobe, active low
//   znUDS/znLDS   in   1   upper/lower data strobes, active low
//   zREAD         in   1   1 = read cycle, 0 = write cycle
//   zA            in   24  byte address (zA[0] ignored)
//   zD            inout 16 data bus; driven only as specified below, else 'z
//   zDOE          in   1   bus data output enable; card may drive zD only while high
//   znCFGIN       in   1   autoconfig chain enable, active low
//   znCFGOUT      out  1   chain enable to next board, active low
//   znSLAVE       out  1   low while this board is selected
//   zDIR          out  1   data buffer direction, 1 = card drives
//   configured    out  1   1 once a base address has been assigned
// BEHAVIOUR
//   - Reset: configured=0, shutup=0, base=0, znCFGOUT=1, znSLAVE=1, zDIR=0, zD='z,
//     FSM IDLE. RAM contents not reset. Reset mid-cycle aborts the cycle, releasing zD at once.
//   - All bus inputs pass 2-FF synchronisers; the FSM uses synchronised copies only.
//   - Select: AC_SEL = !configured & !shutup & !znCFGIN & zA[23:16]==8'hE8;
//     MEM_SEL = configured & zA[23:22]==base[7:6] (zA sampled at the AS falling edge).
//   - FSM: IDLE -(AS fell & sel)-> WAIT_DS -(UDS|LDS low)-> ACCESS -> WAIT_END
//     -(AS high)-> IDLE. AS rising in any state returns to IDLE. Unselected cycles stay in IDLE.
//   - znSLAVE=0 from WAIT_DS to IDLE. zDIR = selected & zREAD.
//   - zD driven iff selected & zREAD & zDOE & state!=IDLE; released within 2 clocks of
//     zDOE or AS going inactive.
//   - Write: one write per cycle, in ACCESS, data latched from zD synchronised in WAIT_DS.
//     UDS gates D15:8, LDS gates D7:0.
//   - Autoconfig read (offset=zA[7:0]): nibble on D15:12, D11:0=0. Offset $00: ER_TYPE[7:4];
//     $02: ER_TYPE[3:0]; $04/$06: ~PRODUCT_ID hi/lo; $10,$12,$14,$16: ~MANUF_ID
//     nibbles MSB-first; all other offsets 4'hF (inverted zero).
//   - Autoconfig write: $48 with UDS: base<=D15:8, configured<=1. $4C: shutup<=1.
//     Other offsets and LDS-only writes are ignored.
//   - znCFGOUT = !(configured | shutup); it never returns high except by reset.
//   - Memory: RAM word = zA[RAM_AW:1]; reads return the full 16-bit word regardless of strobes.
//     Read data is valid within 3 clocks of DS low.
//   - Write then read of the same word returns the written value; the window wraps modulo
//     2^RAM_AW words.
// TESTING
//   1 Reset, znCFGIN=0, read $E80000 -> zD[15:12]=4'hC, znSLAVE=0; read $E80002 -> 4'h7.
//   2 Read $E80010 -> 4'h9 (~6); $E80050 -> 4'hF; znCFGIN=1 -> no response, znSLAVE=1.
//   3 Write 16'h6000 UDS+LDS to $E80048 -> configured=1, znCFGOUT=0;
//     further $E8xxxx cycles are ignored.
//   4 Write 16'hBEEF to $600010, then read $600010 -> 16'hBEEF; read $600410 (alias) -> 16'hBEEF.
//   5 Write 16'h12xx UDS-only to $600010 -> reads 16'h12EF.
//   6 Write to $4C -> znCFGOUT=0, configured=0. Assert reset during a read -> zD='z next clock.

Source files
------------

// File: rtl/z2_autoconfig_slave.sv
// z2_autoconfig_slave
//   Zorro II slave for the graphics card. Before configuration it answers the
//   Autoconfig space at $E80000 (when the chain enable znCFGIN is low). Once the
//   host writes a base address, it answers a 4 MB window in which a 2^RAM_AW x 16
//   on-chip RAM aliases repeatedly. Every bus input is treated as asynchronous and
//   passes a 2-FF synchroniser into the z_sample_clk domain; the FSM only ever
//   looks at the synchronised copies.
//
//   Ports
//     z_sample_clk  in     sole clock (100 MHz)
//     reset         in     asynchronous, active-high
//     znAS          in     address strobe, active low
//     znUDS/znLDS   in     upper/lower data strobes, active low
//     zREAD         in     1 = read cycle, 0 = write cycle
//     zA[23:0]      in     byte address (bit 0 ignored)
//     zD[15:0]      inout  data bus, driven only during selected reads with zDOE high
//     zDOE          in     card may drive zD only while high
//     znCFGIN       in     autoconfig chain enable, active low
//     znCFGOUT      out    chain enable to the next board, active low
//     znSLAVE       out    low while this board owns the cycle
//     zDIR          out    data buffer direction, 1 = card drives
//     configured    out    1 once a base address has been assigned
//     dbgState[1:0] out    current bus FSM state (IDLE/WAIT_DS/ACCESS/WAIT_END)
//
//   Bus handshake: a cycle starts on the synchronised falling edge of znAS. The
//   board claims it only if the address selects it at that instant. A data strobe
//   going low moves the FSM into ACCESS, which performs exactly one write (for
//   write cycles); znAS going high ends the cycle from any state.
module z2_autoconfig_slave #(
  parameter logic [15:0] MANUF_ID   = 16'h6D6E,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [7:0]  ER_TYPE    = 8'hC7,
  parameter int          RAM_AW     = 9
) (
  input  logic        z_sample_clk,
  input  logic        reset,
  input  logic        znAS,
  input  logic        znUDS,
  input  logic        znLDS,
  input  logic        zREAD,
  input  logic [23:0] zA,
  inout  wire  [15:0] zD,
  input  logic        zDOE,
  input  logic        znCFGIN,
  output logic        znCFGOUT,
  output logic        znSLAVE,
  output logic        zDIR,
  output logic        configured,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    ACCESS   = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  // Synchroniser vector: {AS, UDS, LDS, READ, DOE, CFGIN, A[23:0], D[15:0]}.
  // Reset value keeps the strobes inactive so no cycle is seen coming out of reset.
  localparam logic [45:0] SYNC_RST = {3'b111, 1'b0, 1'b0, 1'b1, 24'h0, 16'h0};

  logic [45:0] sync1, sync2;
  logic        asS, udsN, ldsN, rdS, doeS, cfgInN;
  logic [23:0] aS;
  logic [15:0] dS;

  always_ff @(posedge z_sample_clk or posedge reset) begin
    if (reset) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {znAS, znUDS, znLDS, zREAD, zDOE, znCFGIN, zA, zD};
      sync2 <= sync1;
    end
  end

  assign {asS, udsN, ldsN, rdS, doeS, cfgInN, aS, dS} = sync2;

  // zA[0] and the address bits between the RAM index and the window select
  // carry no meaning for this board.
  logic unusedBits;
  assign unusedBits = ^{zA[0], aS};

  state_t             state, stateNext;
  logic               asPrev, asFell;
  logic               shutup;
  logic [7:0]         base;
  logic               cycIsAc;
  logic [7:0]         acOff;
  logic [RAM_AW-1:0]  wordAddr;
  logic [15:0]        wrData;
  logic               udsEn, ldsEn;
  logic               acSelNow, memSelNow, latchCyc, driveEn, doWrite;
  logic [15:0]        ramQ, rdData;
  logic [3:0]         acNibble;
  logic [15:0]        ram [0:(2**RAM_AW)-1];

  assign asFell    = asPrev & ~asS;
  assign acSelNow  = ~configured & ~shutup & ~cfgInN & (aS[23:16] == 8'hE8);
  assign memSelNow = configured & (aS[23:22] == base[7:6]);

  always_ff @(posedge z_sample_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    latchCyc  = 1'b0;
    znSLAVE   = 1'b1;
    zDIR      = 1'b0;
    driveEn   = 1'b0;
    doWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (asFell && (acSelNow || memSelNow)) begin
          stateNext = WAIT_DS;
          latchCyc  = 1'b1;
        end
      end
      WAIT_DS: begin
        if (asS)                stateNext = IDLE;
        else if (!udsN || !ldsN) stateNext = ACCESS;
      end
      ACCESS: begin
        doWrite   = ~rdS;
        stateNext = asS ? IDLE : WAIT_END;
      end
      WAIT_END: begin
        if (asS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (state != IDLE) begin
      znSLAVE = 1'b0;
      zDIR    = rdS;
      // Gating on the synchronised AS (not just the state) releases the bus
      // two clocks after AS rises instead of three.
      driveEn = rdS & doeS & ~asS;
    end
  end

  assign dbgState = state;
  assign znCFGOUT = ~(configured | shutup);

  always_ff @(posedge z_sample_clk or posedge reset) begin
    if (reset) begin
      asPrev     <= 1'b1;
      configured <= 1'b0;
      shutup     <= 1'b0;
      base       <= 8'h00;
      cycIsAc    <= 1'b0;
      acOff      <= 8'h00;
      wordAddr   <= '0;
      wrData     <= 16'h0000;
      udsEn      <= 1'b0;
      ldsEn      <= 1'b0;
    end else begin
      asPrev <= asS;
      if (latchCyc) begin
        cycIsAc  <= acSelNow;
        acOff    <= aS[7:0];
        wordAddr <= aS[RAM_AW:1];
      end
      // Keep sampling while waiting for a strobe; the last sample is the one
      // taken together with the strobe edge that moves us into ACCESS.
      if (state == WAIT_DS) begin
        wrData <= dS;
        udsEn  <= ~udsN;
        ldsEn  <= ~ldsN;
      end
      if (doWrite && cycIsAc) begin
        if (acOff == 8'h48 && udsEn) begin
          base       <= wrData[15:8];
          configured <= 1'b1;
        end
        if (acOff == 8'h4C) shutup <= 1'b1;
      end
    end
  end

  // RAM is not reset; reads are registered every clock from the latched address,
  // which is stable long before the data strobe reaches the FSM.
  always_ff @(posedge z_sample_clk) begin
    if (doWrite && !cycIsAc) begin
      if (udsEn) ram[wordAddr][15:8] <= wrData[15:8];
      if (ldsEn) ram[wordAddr][7:0]  <= wrData[7:0];
    end
    ramQ <= ram[wordAddr];
  end

  // Autoconfig registers read back as inverted values except er_Type;
  // unused offsets therefore read as an inverted zero.
  always_comb begin
    acNibble = 4'hF;
    case (acOff)
      8'h00: acNibble = ER_TYPE[7:4];
      8'h02: acNibble = ER_TYPE[3:0];
      8'h04: acNibble = ~PRODUCT_ID[7:4];
      8'h06: acNibble = ~PRODUCT_ID[3:0];
      8'h10: acNibble = ~MANUF_ID[15:12];
      8'h12: acNibble = ~MANUF_ID[11:8];
      8'h14: acNibble = ~MANUF_ID[7:4];
      8'h16: acNibble = ~MANUF_ID[3:0];
      default: acNibble = 4'hF;
    endcase
  end

  assign rdData = cycIsAc ? {acNibble, 12'h000} : ramQ;
  assign zD     = driveEn ? rdData : 16'hzzzz;

endmodule

// File: tb/tb_z2_autoconfig_slave.sv
module tb_z2_autoconfig_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        znAS, znUDS, znLDS, zREAD, zDOE, znCFGIN;
  logic [23:0] zA;
  wire  [15:0] zD;
  logic        znCFGOUT, znSLAVE, zDIR, configured;
  logic [1:0]  dbgState;
  logic        tbDrv;
  logic [15:0] tbData;

  int totalChecks = 0;
  int failCount   = 0;

  logic [15:0] rdVal;
  logic        rdSlv, rdDir, wrSlv;

  assign zD = tbDrv ? tbData : 16'hzzzz;

  z2_autoconfig_slave dut (
    .z_sample_clk (clk),
    .reset        (reset),
    .znAS         (znAS),
    .znUDS        (znUDS),
    .znLDS        (znLDS),
    .zREAD        (zREAD),
    .zA           (zA),
    .zD           (zD),
    .zDOE         (zDOE),
    .znCFGIN      (znCFGIN),
    .znCFGOUT     (znCFGOUT),
    .znSLAVE      (znSLAVE),
    .zDIR         (zDIR),
    .configured   (configured),
    .dbgState     (dbgState)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    waitClk(3);
    reset = 1'b0;
    waitClk(3);
  endtask

  // Driver tasks: one complete bus cycle each, sampling outputs at a negedge.
  task automatic busRead(input logic [23:0] addr, output logic [15:0] data,
                         output logic slv, output logic dir);
    zA = addr; zREAD = 1'b1; zDOE = 1'b1;
    waitClk(2);
    znAS = 1'b0;
    waitClk(2);
    znUDS = 1'b0; znLDS = 1'b0;
    waitClk(6);
    data = zD; slv = znSLAVE; dir = zDIR;
    znAS = 1'b1; znUDS = 1'b1; znLDS = 1'b1; zDOE = 1'b0;
    waitClk(6);
  endtask

  task automatic busWrite(input logic [23:0] addr, input logic [15:0] data,
                          input logic uds, input logic lds, output logic slv);
    zA = addr; zREAD = 1'b0; zDOE = 1'b0; tbDrv = 1'b1; tbData = data;
    waitClk(2);
    znAS = 1'b0;
    waitClk(2);
    znUDS = ~uds; znLDS = ~lds;
    waitClk(6);
    slv = znSLAVE;
    znAS = 1'b1; znUDS = 1'b1; znLDS = 1'b1;
    waitClk(1);
    tbDrv = 1'b0;
    waitClk(5);
  endtask

  initial begin
    znAS = 1'b1; znUDS = 1'b1; znLDS = 1'b1; zREAD = 1'b1; zDOE = 1'b0;
    znCFGIN = 1'b0; zA = 24'h0; tbDrv = 1'b0; tbData = 16'h0;
    doReset();

    // Reset state
    check("rst_configured", {31'd0, configured}, 32'd0);
    check("rst_cfgout",     {31'd0, znCFGOUT},   32'd1);
    check("rst_slave",      {31'd0, znSLAVE},    32'd1);
    check("rst_dir",        {31'd0, zDIR},       32'd0);
    check("rst_state",      {30'd0, dbgState},   32'd0);

    // Autoconfig reads: er_Type nibbles, inverted manufacturer, unused offset
    busRead(24'hE80000, rdVal, rdSlv, rdDir);
    check("ac00_data",  {16'd0, rdVal}, 32'h0000C000);
    check("ac00_slave", {31'd0, rdSlv}, 32'd0);
    check("ac00_dir",   {31'd0, rdDir}, 32'd1);
    busRead(24'hE80002, rdVal, rdSlv, rdDir);
    check("ac02_data",  {16'd0, rdVal}, 32'h00007000);
    busRead(24'hE80004, rdVal, rdSlv, rdDir);
    check("ac04_data",  {16'd0, rdVal}, 32'h0000F000);
    busRead(24'hE80006, rdVal, rdSlv, rdDir);
    check("ac06_data",  {16'd0, rdVal}, 32'h0000E000);
    busRead(24'hE80010, rdVal, rdSlv, rdDir);
    check("ac10_data",  {16'd0, rdVal}, 32'h00009000);
    busRead(24'hE80016, rdVal, rdSlv, rdDir);
    check("ac16_data",  {16'd0, rdVal}, 32'h00001000);
    busRead(24'hE80050, rdVal, rdSlv, rdDir);
    check("ac50_data",  {16'd0, rdVal}, 32'h0000F000);

    // Chain not enabled: no response
    znCFGIN = 1'b1;
    busRead(24'hE80000, rdVal, rdSlv, rdDir);
    check("cfgin_hi_slave", {31'd0, rdSlv}, 32'd1);
    check("cfgin_hi_dir",   {31'd0, rdDir}, 32'd0);
    znCFGIN = 1'b0;

    // Base register needs UDS: LDS-only write is ignored
    busWrite(24'hE80048, 16'h0060, 1'b0, 1'b1, wrSlv);
    check("lds48_slave",  {31'd0, wrSlv},      32'd0);
    check("lds48_config", {31'd0, configured}, 32'd0);
    check("lds48_cfgout", {31'd0, znCFGOUT},   32'd1);

    // Configure at $600000
    busWrite(24'hE80048, 16'h6000, 1'b1, 1'b1, wrSlv);
    check("cfg_config", {31'd0, configured}, 32'd1);
    check("cfg_cfgout", {31'd0, znCFGOUT},   32'd0);
    busRead(24'hE80000, rdVal, rdSlv, rdDir);
    check("post_cfg_ac_slave", {31'd0, rdSlv}, 32'd1);

    // Memory window: write, read back, alias, neighbour word
    busWrite(24'h600010, 16'hBEEF, 1'b1, 1'b1, wrSlv);
    check("mem_wr_slave", {31'd0, wrSlv}, 32'd0);
    busWrite(24'h600012, 16'hA55A, 1'b1, 1'b1, wrSlv);
    busRead(24'h600010, rdVal, rdSlv, rdDir);
    check("mem_rd",       {16'd0, rdVal}, 32'h0000BEEF);
    check("mem_rd_slave", {31'd0, rdSlv}, 32'd0);
    busRead(24'h600410, rdVal, rdSlv, rdDir);
    check("mem_alias",    {16'd0, rdVal}, 32'h0000BEEF);
    busRead(24'h7FF012, rdVal, rdSlv, rdDir);
    check("mem_alias_top", {16'd0, rdVal}, 32'h0000A55A);
    busRead(24'h200010, rdVal, rdSlv, rdDir);
    check("mem_outside_slave", {31'd0, rdSlv}, 32'd1);

    // Upper-byte-only write keeps the low byte
    busWrite(24'h600010, 16'h1234, 1'b1, 1'b0, wrSlv);
    busRead(24'h600010, rdVal, rdSlv, rdDir);
    check("mem_uds_only", {16'd0, rdVal}, 32'h000012EF);

    // Dropping zDOE mid-read releases the bus within two clocks
    zA = 24'h600010; zREAD = 1'b1; zDOE = 1'b1;
    waitClk(2); znAS = 1'b0; waitClk(2); znUDS = 1'b0; znLDS = 1'b0; waitClk(6);
    check("doe_drive", {16'd0, zD}, 32'h000012EF);
    zDOE = 1'b0;
    waitClk(2);
    tbDrv = 1'b1; tbData = 16'h3C3C;
    #1;
    check("doe_release", {16'd0, zD}, 32'h00003C3C);
    tbDrv = 1'b0;
    znAS = 1'b1; znUDS = 1'b1; znLDS = 1'b1;
    waitClk(6);

    // Shut-up: chain passes on without configuring
    doReset();
    busWrite(24'hE8004C, 16'h0000, 1'b1, 1'b1, wrSlv);
    check("shutup_cfgout", {31'd0, znCFGOUT},   32'd0);
    check("shutup_config", {31'd0, configured}, 32'd0);
    busRead(24'hE80000, rdVal, rdSlv, rdDir);
    check("shutup_ac_slave", {31'd0, rdSlv}, 32'd1);

    // Reset in the middle of a read aborts it immediately
    doReset();
    zA = 24'hE80002; zREAD = 1'b1; zDOE = 1'b1;
    waitClk(2); znAS = 1'b0; waitClk(2); znUDS = 1'b0; znLDS = 1'b0; waitClk(6);
    check("midrd_data",  {16'd0, zD},       32'h00007000);
    check("midrd_state", {30'd0, dbgState}, 32'd3);
    reset = 1'b1;
    #1;
    check("abort_state", {30'd0, dbgState}, 32'd0);
    check("abort_slave", {31'd0, znSLAVE},  32'd1);
    check("abort_dir",   {31'd0, zDIR},     32'd0);
    tbDrv = 1'b1; tbData = 16'h5A5A;
    #1;
    check("abort_release", {16'd0, zD}, 32'h00005A5A);
    tbDrv = 1'b0;
    znAS = 1'b1; znUDS = 1'b1; znLDS = 1'b1; zDOE = 1'b0;
    waitClk(2);
    reset = 1'b0;
    waitClk(3);

    $display("%0d/%0d checks passed", totalChecks - failCount, totalChecks);
    $finish;
  end

endmodule
